cp_level_tracker: RTL

//  Downstream consumer of the charge-pump sequencer. Tracks the net pump charge as a signed step count
//  (snk pulse = -1, src pulse = +1) and samples that count whenever the analog comparator watching the

---
 rtl/cp_pkg.sv | 30 +++
 rtl/cp_sync.sv | 30 +++
 rtl/cp_level_tracker.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cp_pkg.sv
// Shared types and helpers for the charge-pump level tracker and its companions.
package cp_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StTrack = 2'd1
  } state_e;

  localparam int StepNone = 0;
  localparam int StepSnk  = -1;
  localparam int StepSrc  = 1;

  // Net step for one cycle; coincident sink and source cancel.
  function automatic int step_of(logic sink_step, logic src_step);
    int s;
    s = StepNone;
    if (sink_step) s = s + StepSnk;
    if (src_step)  s = s + StepSrc;
    return s;
  endfunction

  function automatic int sat_add(int a, int b, int lo, int hi);
    int s;
    s = a + b;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/cp_sync.sv
// Multi-flop synchroniser for an asynchronous analog-comparator input, with a registered
// toggle flag that pulses for one cycle whenever the synchronised level changes.
module cp_sync #(
  parameter int unsigned SYNC_LEN = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_async,
  output logic toggle
);

  logic [SYNC_LEN-1:0] sync_q;
  logic                prev_q;
  logic                toggle_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_LEN-2:0], d_async};
      prev_q   <= sync_q[SYNC_LEN-1];
      toggle_q <= sync_q[SYNC_LEN-1] ^ prev_q;
    end
  end

  assign toggle = toggle_q;

endmodule

// File: rtl/cp_level_tracker.sv
// Tracks net charge-pump steps as a saturating signed level, averages the level over
// 2**AVG_LOG2 comparator trips and offers each average over a valid/ready handshake.
module cp_level_tracker
  import cp_pkg::*;
#(
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned SYNC_LEN = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pump_rst,
  input  logic                    pre_chrg,
  input  logic                    snk,
  input  logic                    src_n,
  input  logic                    cmp_async,
  input  logic                    res_ready,
  output logic                    res_valid,
  output logic signed [CNT_W-1:0] res_data,
  output logic signed [CNT_W-1:0] level,
  output logic                    overrun
);

  localparam int unsigned AccW   = CNT_W + AVG_LOG2;
  localparam int unsigned NumAvg = 1 << AVG_LOG2;
  localparam int          LvlMax = (1 << (CNT_W - 1)) - 1;
  localparam int          LvlMin = -(1 << (CNT_W - 1));

  state_e                  state_q, state_d;
  logic                    snk_q, src_n_q;
  logic                    sink_step, src_step, trip, abort, complete;
  logic signed [CNT_W-1:0] level_q, level_d, level_next;
  logic signed [AccW-1:0]  acc_q, acc_d, level_ext, acc_total;
  logic [4:0]              cnt_q, cnt_d;
  logic                    valid_q, valid_d, overrun_q, overrun_d;
  logic signed [CNT_W-1:0] data_q, data_d;

  cp_sync #(
    .SYNC_LEN (SYNC_LEN)
  ) u_cmp_sync (
    .clk     (clk),
    .reset   (reset),
    .d_async (cmp_async),
    .toggle  (trip)
  );

  always_comb begin
    sink_step  = snk & ~snk_q;
    src_step   = ~src_n & src_n_q;
    abort      = pump_rst | pre_chrg;
    // Trips sample the level with this cycle's step already applied.
    level_next = CNT_W'(sat_add(int'(level_q), step_of(sink_step, src_step), LvlMin, LvlMax));
    level_ext  = AccW'(level_next);
    acc_total  = acc_q + level_ext;

    state_d  = state_q;
    level_d  = level_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    complete = 1'b0;

    if (abort) begin
      state_d = StIdle;
      level_d = '0;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StTrack;
          level_d = '0;
          acc_d   = '0;
          cnt_d   = '0;
        end
        StTrack: begin
          level_d = level_next;
          if (trip) begin
            if (cnt_q == 5'(NumAvg - 1)) begin
              complete = 1'b1;
              acc_d    = '0;
              cnt_d    = '0;
            end else begin
              acc_d = acc_total;
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    valid_d   = valid_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    if (valid_q && res_ready) valid_d = 1'b0;
    if (complete) begin
      if (!valid_q || res_ready) begin
        valid_d = 1'b1;
        data_d  = CNT_W'(acc_total >>> AVG_LOG2);
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      snk_q     <= 1'b0;
      src_n_q   <= 1'b0;
      level_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      snk_q     <= snk;
      src_n_q   <= src_n;
      level_q   <= level_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign res_valid = valid_q;
  assign res_data  = data_q;
  assign level     = level_q;
  assign overrun   = overrun_q;

endmodule
